// File: rtl/regfile_mp.sv
// Purpose: parametrised multi-port integer register file with zero register, write bypass and post-reset clear sweep.
// Latency: read address in cycle t -> rd_data valid after edge t+1; writes land at the edge they are presented.
// Backpressure: rd_stall freezes all rd_data outputs (writes still complete); ready=0 while the clear sweep runs.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    input  logic                     rd_stall,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    output logic                     ready
);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

    logic            state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic [XLEN-1:0] rd_q [NUM_RD];

    // A write to x0 is discarded when register 0 is hardwired to zero.
    logic wr_drop;
    logic wr_fire;

    always_comb begin
        wr_drop = (ZERO_REG != 0) && (wr_addr == '0);
        wr_fire = (state == ST_RUN) && wr_en && !wr_drop;
    end

    // The array is usable exactly when the sweep has finished.
    assign ready = (state == ST_RUN);

    // Sweep FSM: CLEAR zeroes one register per edge, then RUN until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == LAST_REG) begin
                state <= ST_RUN;
            end
        end
    end

    // Array write port: the sweep owns it during CLEAR, writeback owns it during RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_fire) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // Registered read ports: zero during reset/CLEAR, held on stall, otherwise
    // zero-reg, then bypass, then the pre-write array contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_RD; k++) begin
            if (rst || (state == ST_CLEAR)) begin
                rd_q[k] <= '0;
            end else if (!rd_stall) begin
                if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == '0)) begin
                    rd_q[k] <= '0;
                end else if ((BYPASS != 0) && wr_fire && (wr_addr == rd_addr[k*AW +: AW])) begin
                    rd_q[k] <= wr_data;
                end else begin
                    rd_q[k] <= mem[rd_addr[k*AW +: AW]];
                end
            end
        end
    end

    // Pack per-port read registers onto the flat output bus.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*XLEN +: XLEN] = rd_q[k];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Purpose: directed check of regfile_mp across default, no-zero/no-bypass and wide 3-port configurations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises rd_stall hold and the post-reset ready sweep.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instances A (defaults) and B (ZERO_REG=0, BYPASS=0) share one stimulus set.
    logic [9:0]  rd_addr_ab = '0;
    logic        rd_stall_ab = 1'b0;
    logic        wr_en_ab = 1'b0;
    logic [4:0]  wr_addr_ab = '0;
    logic [31:0] wr_data_ab = '0;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        ready_a;
    logic        ready_b;

    // Instance C: NREGS=16, XLEN=64, NUM_RD=3.
    logic [11:0]  rd_addr_c = '0;
    logic         rd_stall_c = 1'b0;
    logic         wr_en_c = 1'b0;
    logic [3:0]   wr_addr_c = '0;
    logic [63:0]  wr_data_c = '0;
    logic [191:0] rd_data_c;
    logic         ready_c;

    regfile_mp u_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_ab), .rd_stall(rd_stall_ab), .rd_data(rd_data_a),
        .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab), .ready(ready_a)
    );

    regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_ab), .rd_stall(rd_stall_ab), .rd_data(rd_data_b),
        .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab), .ready(ready_b)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(3)) u_c (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_c), .rd_stall(rd_stall_c), .rd_data(rd_data_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .ready(ready_c)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr_ab = {a1, a0};
    endtask

    task automatic wr_ab(input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en_ab   = en;
        wr_addr_ab = a;
        wr_data_ab = d;
    endtask

    initial begin
        // Reset held for two edges.
        tick();
        tick();
        chk("rst_ready_a", 64'(ready_a), 64'd0);
        chk("rst_data_a", rd_data_a, 64'd0);
        chk("rst_ready_c", 64'(ready_c), 64'd0);
        rst = 1'b0;

        // Clear sweep: A/B ready on the 32nd edge, C on the 16th.
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("sweep_ready_a_%0d", i), 64'(ready_a), 64'(i == 32));
            chk($sformatf("sweep_ready_b_%0d", i), 64'(ready_b), 64'(i == 32));
            chk($sformatf("sweep_ready_c_%0d", i), 64'(ready_c), 64'(i >= 16));
            if (i <= 16) begin
                chk($sformatf("sweep_data_a_%0d", i), rd_data_a, 64'd0);
            end
        end

        // Cleared register reads zero.
        set_rd(5'd17, 5'd17);
        tick();
        chk("x17_clear_a", rd_data_a, 64'd0);
        chk("x17_clear_b", rd_data_b, 64'd0);

        // Basic write then read on both ports.
        set_rd(5'd0, 5'd0);
        wr_ab(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wr_ab(1'b0, 5'd0, 32'd0);
        set_rd(5'd5, 5'd5);
        tick();
        chk("x5_a", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
        chk("x5_b", rd_data_b, {32'hDEADBEEF, 32'hDEADBEEF});

        // Zero register.
        wr_ab(1'b1, 5'd0, 32'h12345678);
        tick();
        wr_ab(1'b0, 5'd0, 32'd0);
        set_rd(5'd0, 5'd0);
        tick();
        chk("x0_zero_a", rd_data_a, 64'd0);
        chk("x0_nozero_b", rd_data_b, {32'h12345678, 32'h12345678});

        // Bypass: x7 = 0x11 first, then same-edge write and read.
        wr_ab(1'b1, 5'd7, 32'h11);
        tick();
        wr_ab(1'b1, 5'd7, 32'hA5A5A5A5);
        set_rd(5'd7, 5'd7);
        tick();
        chk("byp_a", rd_data_a, {32'hA5A5A5A5, 32'hA5A5A5A5});
        chk("nobyp_b", rd_data_b, {32'h11, 32'h11});
        wr_ab(1'b0, 5'd0, 32'd0);
        tick();
        chk("byp_after_a", rd_data_a, {32'hA5A5A5A5, 32'hA5A5A5A5});
        chk("nobyp_after_b", rd_data_b, {32'hA5A5A5A5, 32'hA5A5A5A5});

        // Stall: port0 shows x3, port1 shows x4.
        wr_ab(1'b1, 5'd3, 32'h33);
        tick();
        wr_ab(1'b1, 5'd4, 32'h4444);
        tick();
        wr_ab(1'b0, 5'd0, 32'd0);
        set_rd(5'd3, 5'd4);
        tick();
        chk("pre_stall_a", rd_data_a, {32'h4444, 32'h33});
        rd_stall_ab = 1'b1;
        wr_ab(1'b1, 5'd3, 32'h44);
        set_rd(5'd4, 5'd4);
        for (int i = 1; i <= 3; i++) begin
            tick();
            wr_ab(1'b0, 5'd0, 32'd0);
            chk($sformatf("stall_a_%0d", i), rd_data_a, {32'h4444, 32'h33});
            chk($sformatf("stall_b_%0d", i), rd_data_b, {32'h4444, 32'h33});
        end
        rd_stall_ab = 1'b0;
        tick();
        chk("unstall_a", rd_data_a, {32'h4444, 32'h4444});
        set_rd(5'd3, 5'd4);
        tick();
        chk("reread_x3_a", rd_data_a, {32'h4444, 32'h44});
        chk("reread_x3_b", rd_data_b, {32'h4444, 32'h44});

        // Wide 3-port instance: write x9, read it back, then reset mid-RUN.
        wr_en_c   = 1'b1;
        wr_addr_c = 4'd9;
        wr_data_c = 64'hFFFF_0000_FFFF_0000;
        tick();
        wr_en_c   = 1'b0;
        rd_addr_c = {4'd9, 4'd9, 4'd9};
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("c_x9_p%0d", k), rd_data_c[k*64 +: 64], 64'hFFFF_0000_FFFF_0000);
        end
        rst = 1'b1;
        tick();
        chk("c_rst_ready", 64'(ready_c), 64'd0);
        chk("c_rst_data", rd_data_c[63:0], 64'd0);
        rst = 1'b0;
        wr_en_c   = 1'b1;
        wr_addr_c = 4'd9;
        wr_data_c = 64'h1234;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("c_sweep_ready_%0d", i), 64'(ready_c), 64'(i == 16));
            chk($sformatf("c_sweep_data_%0d", i), rd_data_c[127:64], 64'd0);
        end
        wr_en_c = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("c_x9_cleared_p%0d", k), rd_data_c[k*64 +: 64], 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
